pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 8, width of the control bundle (MEM_R_EN, MEM_W_EN, WB_EN, EXE_CMD, brTaken, ...).
REQ-002 SHALL have parameter DATA_W, default 128, width of the data bundle (val1, val2, ST_value, PC).
REQ-003 SHALL have parameter TAG_W, default 15, width of the register-address bundle (dest, src1, src2).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream stage holds a live instruction.
REQ-007 in_ready  output  1  stage accepts the input this cycle.
REQ-008 in_ctrl  input  CTRL_W  control bundle.
REQ-009 in_tag  input  TAG_W  register-address bundle.
REQ-010 in_data  input  DATA_W  data bundle.
REQ-011 flush  input  1  squash everything held and everything presented this cycle.
REQ-012 out_valid  output  1  downstream copy is live.
REQ-013 out_ready  input  1  downstream consumes the output this cycle.
REQ-014 out_ctrl / out_tag / out_data  output  CTRL_W / TAG_W / DATA_W  registered bundles.
REQ-015 occupancy  output  2  entries held, 0..2.

Function
REQ-016 SHALL accept an input on a cycle with in_valid && in_ready && !flush (a "push").
REQ-017 SHALL consume the output on a cycle with out_valid && out_ready (a "pop").
REQ-018 SHALL present a pushed entry on out_* exactly 1 cycle after the push when the main register is empty or popped that cycle.
REQ-019 SHALL keep out_valid, out_ctrl, out_tag and out_data bit-stable while out_valid && !out_ready && !flush.
REQ-020 SHALL drive out_ctrl to all zeros whenever out_valid is 0 (bubble = NOP; stray write or branch enables are impossible).
REQ-021 SHALL leave out_tag and out_data holding their last values when out_valid falls.
REQ-022 SHALL deliver entries in push order, with no loss and no duplication.
REQ-023 On flush SHALL, at the next edge, set out_valid=0, out_ctrl=0 and occupancy=0, and discard any same-cycle input; flush overrides push and pop.
REQ-024 SHALL keep in_ready ignored by the push rule during flush; the push is dropped regardless.
REQ-025 On a pop with no push and no held second entry, SHALL set out_valid=0 at the next edge.
REQ-026 On a simultaneous push and pop with one entry held, SHALL load the new entry into the main register; occupancy stays 1.
REQ-027 SHALL make occupancy equal to the number of pushes minus pops since the last reset or flush, saturating never beyond 2.

Reset
REQ-028 While rst is high at an edge, SHALL set out_valid=0, out_ctrl=0, out_tag=0, out_data=0, occupancy=0 and clear the skid entry.
REQ-029 Reset SHALL dominate flush, push and pop; in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN defined: SHALL instantiate a second (skid) entry.
  - in_ready SHALL be registered, equal to !(occupancy==2).
  - A push while the main register is full and not popped SHALL go to the skid entry.
  - On a pop with skid full, SHALL move the skid entry to main next cycle.
  - occupancy SHALL range 0..2.
REQ-031 Macro PIPE_STAGE_SKID_EN undefined: SHALL have a single entry.
  - in_ready SHALL equal !out_valid || out_ready (combinational).
  - occupancy SHALL never exceed 1.
  - All other requirements SHALL be unchanged.

Verification
REQ-032 Reset then stream: push ctrl=8'h15, data=0x...0A, tag=0x0C3 for 4 back-to-back cycles with out_ready=1 -> each appears 1 cycle later; occupancy=1 throughout.
REQ-033 Backpressure (SKID_EN): out_ready=0 with 3 pushes A,B,C -> A held on out_*, B in skid, in_ready=0 after 2 accepts, C not accepted; then out_ready=1 -> A, B, C emerge in order, 1 per cycle.
REQ-034 Backpressure (no SKID_EN): out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_* stable for 5 cycles.
REQ-035 Flush: 2 entries held plus a push in the flush cycle -> next cycle out_valid=0, out_ctrl=8'h00, occupancy=0; no dropped entry ever appears.
REQ-036 Drain: pop the last entry with in_valid=0 -> out_valid=0 and out_ctrl=0 while out_data still equals the last value.
REQ-037 Reset mid-operation: rst=1 with flush=1, in_valid=1 and occupancy=2 -> all outputs 0 next cycle; in_ready=1 after release.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with valid/ready handshake, flush and NOP bubbles.
// Define PIPE_STAGE_SKID_EN for a second (skid) entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int TAG_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_v_q, main_v_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [TAG_W-1:0]  main_tag_q, main_tag_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              push, pop;

  assign push = in_valid && in_ready && !flush;
  assign pop  = main_v_q && out_ready;

  assign out_valid = main_v_q;
  // Control is gated so a bubble can never carry a write or branch enable.
  assign out_ctrl  = main_v_q ? main_ctrl_q : '0;
  assign out_tag   = main_tag_q;
  assign out_data  = main_data_q;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_v_q, skid_v_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              rdy_q, rdy_d;

  assign in_ready  = rdy_q;
  assign occupancy = 2'(main_v_q) + 2'(skid_v_q);

  always_comb begin
    main_v_d    = main_v_q;
    main_ctrl_d = main_ctrl_q;
    main_tag_d  = main_tag_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_tag_d  = skid_tag_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_v_d    = 1'b0;
      main_ctrl_d = '0;
      skid_v_d    = 1'b0;
    end else if (pop) begin
      if (skid_v_q) begin
        main_ctrl_d = skid_ctrl_q;
        main_tag_d  = skid_tag_q;
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
      end else if (push) begin
        main_ctrl_d = in_ctrl;
        main_tag_d  = in_tag;
        main_data_d = in_data;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (push) begin
      if (main_v_q) begin
        skid_v_d    = 1'b1;
        skid_ctrl_d = in_ctrl;
        skid_tag_d  = in_tag;
        skid_data_d = in_data;
      end else begin
        main_v_d    = 1'b1;
        main_ctrl_d = in_ctrl;
        main_tag_d  = in_tag;
        main_data_d = in_data;
      end
    end
    // Stage is full exactly when the skid entry is occupied.
    rdy_d = !skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      main_ctrl_q <= '0;
      main_tag_q  <= '0;
      main_data_q <= '0;
      skid_v_q    <= 1'b0;
      skid_ctrl_q <= '0;
      skid_tag_q  <= '0;
      skid_data_q <= '0;
      rdy_q       <= 1'b1;
    end else begin
      main_v_q    <= main_v_d;
      main_ctrl_q <= main_ctrl_d;
      main_tag_q  <= main_tag_d;
      main_data_q <= main_data_d;
      skid_v_q    <= skid_v_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_tag_q  <= skid_tag_d;
      skid_data_q <= skid_data_d;
      rdy_q       <= rdy_d;
    end
  end
`else
  assign in_ready  = !main_v_q || out_ready;
  assign occupancy = {1'b0, main_v_q};

  always_comb begin
    main_v_d    = main_v_q;
    main_ctrl_d = main_ctrl_q;
    main_tag_d  = main_tag_q;
    main_data_d = main_data_q;
    if (flush) begin
      main_v_d    = 1'b0;
      main_ctrl_d = '0;
    end else if (push) begin
      main_v_d    = 1'b1;
      main_ctrl_d = in_ctrl;
      main_tag_d  = in_tag;
      main_data_d = in_data;
    end else if (pop) begin
      main_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      main_ctrl_q <= '0;
      main_tag_q  <= '0;
      main_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_ctrl_q <= main_ctrl_d;
      main_tag_q  <= main_tag_d;
      main_data_q <= main_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [7:0]   c;
    logic [14:0]  t;
    logic [127:0] d;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_ctrl = '0;
  logic [14:0]  in_tag = '0;
  logic [127:0] in_data = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_ctrl;
  logic [14:0]  out_tag;
  logic [127:0] out_data;
  logic [1:0]   occupancy;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .TAG_W(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_tag(in_tag), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_tag(out_tag), .out_data(out_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          armed  = 1'b0;

  // Reference: held entries in order; out_* shows the head, tag/data keep the last head.
  ent_t         q[$];
  logic [14:0]  last_tag  = '0;
  logic [127:0] last_data = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic ent_t mk(input logic [7:0] c, input logic [14:0] t, input logic [127:0] d);
    ent_t e;
    e.c = c; e.t = t; e.d = d;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    return mk(8'($urandom), 15'($urandom), {$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic step(input logic r, input logic v, input ent_t e, input logic f, input logic ordy);
    logic exp_rdy;
    @(negedge clk);
    rst = r; in_valid = v; in_ctrl = e.c; in_tag = e.t; in_data = e.d;
    flush = f; out_ready = ordy;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = (q.size() == 0) || ordy;
`endif
    if (armed) begin
      check("out_valid", 128'(out_valid), 128'(q.size() > 0));
      check("out_ctrl", 128'(out_ctrl), (q.size() > 0) ? 128'(q[0].c) : 128'd0);
      check("out_tag", 128'(out_tag), 128'(last_tag));
      check("out_data", out_data, last_data);
      check("occupancy", 128'(occupancy), 128'(q.size()));
      check("in_ready", 128'(in_ready), 128'(exp_rdy));
    end
    if (r) begin
      q.delete();
      last_tag  = '0;
      last_data = '0;
      armed     = 1'b1;
    end else if (f) begin
      q.delete();
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && exp_rdy) q.push_back(e);
      if (q.size() > 0) begin
        last_tag  = q[0].t;
        last_data = q[0].d;
      end
    end
  endtask

  initial begin
    ent_t z;
    ent_t a, b, c;
    z = mk('0, '0, '0);

    step(1, 0, z, 0, 0);
    step(1, 1, rnd_ent(), 1, 1);
    step(0, 0, z, 0, 1);

    // Back-to-back stream with downstream always ready.
    for (int i = 0; i < 4; i++) step(0, 1, mk(8'h15, 15'h0C3, 128'h0A + 128'(i)), 0, 1);
    step(0, 0, z, 0, 1);
    step(0, 0, z, 0, 1);

    // Backpressure: A, B, C offered while stalled, then release.
    a = rnd_ent(); b = rnd_ent(); c = rnd_ent();
    step(0, 1, a, 0, 0);
    step(0, 1, b, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, c, 0, 0);
    step(0, 1, c, 0, 1);
    step(0, 1, c, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, z, 0, 1);

    // Flush with two entries held and a push in the same cycle.
    step(0, 1, rnd_ent(), 0, 0);
    step(0, 1, rnd_ent(), 0, 0);
    step(0, 1, rnd_ent(), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, z, 0, 1);

    // Drain: last entry popped with nothing behind it.
    step(0, 1, rnd_ent(), 0, 0);
    step(0, 0, z, 0, 0);
    step(0, 0, z, 0, 1);
    step(0, 0, z, 0, 1);

    // Reset while full, flushing and pushing.
    step(0, 1, rnd_ent(), 0, 0);
    step(0, 1, rnd_ent(), 0, 0);
    step(1, 1, rnd_ent(), 1, 0);
    step(0, 0, z, 0, 0);
    step(0, 1, rnd_ent(), 0, 1);
    step(0, 0, z, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 127) == 0), ($urandom_range(0, 3) != 0), rnd_ent(),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0));
    end
    step(0, 0, z, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
